mc_control: RTL

Multicycle main controller for the LEGv8 core. It decodes the 11-bit opcode held in the instruction register and sequences one instruction over 3–5+ cycles. In each state it drives the datapath mux selects, the write strobes and the 4-bit `ALUControl` code consumed by the shared ALU. It consumes the ALU `zero` flag for CBZ. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/mc_control.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control.sv
// Multicycle LEGv8 main controller: decodes the IR opcode and sequences each
// instruction through fetch, decode, execute, memory and write-back states.
module mc_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg2loc,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  ALUControl,
    output logic        illegal
);

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_PASS_B = 4'b0111;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_R_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_LD_WB,
        S_MEM_WR,
        S_CBZ,
        S_BR
    } state_t;

    // Registered copy of the per-state (Moore) outputs, plus state-class flags
    // used to build the few outputs gated by live inputs.
    typedef struct packed {
        logic       fetch;
        logic       decode;
        logic       exec_r;
        logic       cbz;
        logic       br;
        logic       pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg2loc;
        logic       reg_write;
        logic       mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
    } moore_t;

    state_t state;
    state_t next_state;
    moore_t mo;

    logic is_add, is_sub, is_and, is_orr;
    logic is_ldur, is_stur, is_cbz, is_b;
    logic is_rtype, is_mem, legal;
    logic [3:0] rtype_ctl;

    function automatic moore_t moore_of(input state_t s);
        moore_t m;
        m = '0;
        m.alu_ctl = ALU_ADD;
        case (s)
            S_FETCH: begin
                m.fetch     = 1'b1;
                m.mem_read  = 1'b1;
                m.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                m.decode    = 1'b1;
                m.alu_src_a = 2'b10;
                m.alu_src_b = 2'b11;
            end
            S_EXEC_R: begin
                m.exec_r    = 1'b1;
                m.alu_src_a = 2'b01;
            end
            S_R_WB: m.reg_write = 1'b1;
            S_MEM_ADDR: begin
                m.alu_src_a = 2'b01;
                m.alu_src_b = 2'b10;
                m.reg2loc   = 1'b1;
            end
            S_MEM_RD: begin
                m.mem_read = 1'b1;
                m.i_or_d   = 1'b1;
            end
            S_LD_WB: begin
                m.reg_write  = 1'b1;
                m.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                m.mem_write = 1'b1;
                m.i_or_d    = 1'b1;
                m.reg2loc   = 1'b1;
            end
            S_CBZ: begin
                m.cbz     = 1'b1;
                m.reg2loc = 1'b1;
                m.pc_src  = 1'b1;
                m.alu_ctl = ALU_PASS_B;
            end
            S_BR: begin
                m.br     = 1'b1;
                m.pc_src = 1'b1;
            end
            default: m.fetch = 1'b0;
        endcase
        return m;
    endfunction

    always_comb begin
        is_add   = (op == OP_ADD);
        is_sub   = (op == OP_SUB);
        is_and   = (op == OP_AND);
        is_orr   = (op == OP_ORR);
        is_ldur  = (op == OP_LDUR);
        is_stur  = (op == OP_STUR);
        is_cbz   = (op[10:3] == OP_CBZ);
        is_b     = (op[10:5] == OP_B);
        is_rtype = is_add | is_sub | is_and | is_orr;
        is_mem   = is_ldur | is_stur;
        legal    = is_rtype | is_mem | is_cbz | is_b;
    end

    always_comb begin
        rtype_ctl = ALU_ADD;
        if (is_sub)
            rtype_ctl = ALU_SUB;
        else if (is_and)
            rtype_ctl = ALU_AND;
        else if (is_orr)
            rtype_ctl = ALU_OR;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_rtype)
                    next_state = S_EXEC_R;
                else if (is_mem)
                    next_state = S_MEM_ADDR;
                else if (is_cbz)
                    next_state = S_CBZ;
                else if (is_b)
                    next_state = S_BR;
                else
                    next_state = S_FETCH;
            end
            S_EXEC_R:   next_state = S_R_WB;
            S_R_WB:     next_state = S_FETCH;
            S_MEM_ADDR: begin
                if (is_ldur)
                    next_state = S_MEM_RD;
                else if (is_stur)
                    next_state = S_MEM_WR;
                else
                    next_state = S_FETCH;
            end
            S_MEM_RD:   next_state = mem_ready ? S_LD_WB : S_MEM_RD;
            S_LD_WB:    next_state = S_FETCH;
            S_MEM_WR:   next_state = mem_ready ? S_FETCH : S_MEM_WR;
            S_CBZ:      next_state = S_FETCH;
            S_BR:       next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            mo    <= moore_of(S_FETCH);
        end else begin
            state <= next_state;
            mo    <= moore_of(next_state);
        end
    end

    // Strobes are masked by reset combinationally so an in-flight write is
    // suppressed in the very cycle reset rises, not one cycle later.
    always_comb begin
        pc_write   = ~reset & ((mo.fetch & mem_ready) | (mo.cbz & zero) | mo.br);
        pc_src     = mo.pc_src;
        ir_write   = ~reset & mo.fetch & mem_ready;
        i_or_d     = mo.i_or_d;
        mem_read   = mo.mem_read;
        mem_write  = ~reset & mo.mem_write;
        reg2loc    = mo.reg2loc | (mo.decode & (is_stur | is_cbz));
        reg_write  = ~reset & mo.reg_write;
        mem_to_reg = mo.mem_to_reg;
        alu_src_a  = mo.alu_src_a;
        alu_src_b  = mo.alu_src_b;
        ALUControl = mo.exec_r ? rtype_ctl : mo.alu_ctl;
        illegal    = ~reset & mo.decode & ~legal;
    end

endmodule
